// File: rtl/sha2_compress_core_if.sv
`default_nettype none
// ============================================================================
// Module      : sha2_compress_core_if
// Description : Bundles the block-level handshake and data buses of
//               sha2_compress_core.
//               master - block feeder / digest consumer
//               slave  - the compression core
//   start_in       request to compress one block (sampled in IDLE only)
//   state_in       chaining value H0..H7, H0 in the MSBs
//   msg_valid_in   msg_in carries schedule word W_t
//   msg_in         schedule word W_t, supplied in order t = 0..ROUNDS-1
//   msg_ready_out  core accepts W_t this cycle
//   state_out      updated chaining value, same packing as state_in
//   valid_out      state_out is valid
//   out_ready_in   consumer accepts state_out
//   busy_out       core is not idle
//   round_out      current round index t
// Revision    : 1.0 - initial release
// ============================================================================
interface sha2_compress_core_if #(
  parameter int WORD_W = 32
);
  logic                  start_in;
  logic [8*WORD_W-1:0]   state_in;
  logic                  msg_valid_in;
  logic [WORD_W-1:0]     msg_in;
  logic                  msg_ready_out;
  logic [8*WORD_W-1:0]   state_out;
  logic                  valid_out;
  logic                  out_ready_in;
  logic                  busy_out;
  logic [6:0]            round_out;

  modport master (
    output start_in, state_in, msg_valid_in, msg_in, out_ready_in,
    input  msg_ready_out, state_out, valid_out, busy_out, round_out
  );

  modport slave (
    input  start_in, state_in, msg_valid_in, msg_in, out_ready_in,
    output msg_ready_out, state_out, valid_out, busy_out, round_out
  );
endinterface
`default_nettype wire

// File: rtl/sha2_compress_core.sv
`default_nettype none
// ============================================================================
// Module      : sha2_compress_core
// Description : Iterative SHA-256 / SHA-512 compression function. One round
//               per accepted schedule word; the message schedule is supplied
//               externally. WORD_W=32 selects SHA-256, WORD_W=64 SHA-512.
//               OUT_HOLD=1 holds the digest until out_ready_in, OUT_HOLD=0
//               presents it as a single-cycle valid_out pulse.
// Ports       : CLK  - clock, all state updates on the rising edge
//               RST  - synchronous active-high reset
//               bus  - sha2_compress_core_if.slave (handshake and data)
// Revision    : 1.0 - initial release
// ============================================================================
module sha2_compress_core #(
  parameter int WORD_W   = 32,
  parameter bit OUT_HOLD = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  sha2_compress_core_if.slave  bus
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;

  localparam int c_s0_r0 = (WORD_W == 64) ? 28 : 2;
  localparam int c_s0_r1 = (WORD_W == 64) ? 34 : 13;
  localparam int c_s0_r2 = (WORD_W == 64) ? 39 : 22;
  localparam int c_s1_r0 = (WORD_W == 64) ? 14 : 6;
  localparam int c_s1_r1 = (WORD_W == 64) ? 18 : 11;
  localparam int c_s1_r2 = (WORD_W == 64) ? 41 : 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WORD_W-1:0]    r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [8*WORD_W-1:0]  r_hsave;
  logic [8*WORD_W-1:0]  r_digest;
  logic [6:0]           r_t;

  logic                 w_beat;
  logic [63:0]          w_kfull;
  logic [WORD_W-1:0]    w_k;
  logic [WORD_W-1:0]    w_sig0, w_sig1, w_ch, w_maj, w_t1, w_t2;
  logic [8*WORD_W-1:0]  w_final;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // SHA-512 round constants. The SHA-256 constants are exactly the upper
  // 32 bits of the first 64 entries, so one table serves both widths.
  function automatic logic [63:0] k_lookup(input logic [6:0] idx);
    logic [63:0] k;
    case (idx)
      7'd0:  k = 64'h428a2f98d728ae22; 7'd1:  k = 64'h7137449123ef65cd;
      7'd2:  k = 64'hb5c0fbcfec4d3b2f; 7'd3:  k = 64'he9b5dba58189dbbc;
      7'd4:  k = 64'h3956c25bf348b538; 7'd5:  k = 64'h59f111f1b605d019;
      7'd6:  k = 64'h923f82a4af194f9b; 7'd7:  k = 64'hab1c5ed5da6d8118;
      7'd8:  k = 64'hd807aa98a3030242; 7'd9:  k = 64'h12835b0145706fbe;
      7'd10: k = 64'h243185be4ee4b28c; 7'd11: k = 64'h550c7dc3d5ffb4e2;
      7'd12: k = 64'h72be5d74f27b896f; 7'd13: k = 64'h80deb1fe3b1696b1;
      7'd14: k = 64'h9bdc06a725c71235; 7'd15: k = 64'hc19bf174cf692694;
      7'd16: k = 64'he49b69c19ef14ad2; 7'd17: k = 64'hefbe4786384f25e3;
      7'd18: k = 64'h0fc19dc68b8cd5b5; 7'd19: k = 64'h240ca1cc77ac9c65;
      7'd20: k = 64'h2de92c6f592b0275; 7'd21: k = 64'h4a7484aa6ea6e483;
      7'd22: k = 64'h5cb0a9dcbd41fbd4; 7'd23: k = 64'h76f988da831153b5;
      7'd24: k = 64'h983e5152ee66dfab; 7'd25: k = 64'ha831c66d2db43210;
      7'd26: k = 64'hb00327c898fb213f; 7'd27: k = 64'hbf597fc7beef0ee4;
      7'd28: k = 64'hc6e00bf33da88fc2; 7'd29: k = 64'hd5a79147930aa725;
      7'd30: k = 64'h06ca6351e003826f; 7'd31: k = 64'h142929670a0e6e70;
      7'd32: k = 64'h27b70a8546d22ffc; 7'd33: k = 64'h2e1b21385c26c926;
      7'd34: k = 64'h4d2c6dfc5ac42aed; 7'd35: k = 64'h53380d139d95b3df;
      7'd36: k = 64'h650a73548baf63de; 7'd37: k = 64'h766a0abb3c77b2a8;
      7'd38: k = 64'h81c2c92e47edaee6; 7'd39: k = 64'h92722c851482353b;
      7'd40: k = 64'ha2bfe8a14cf10364; 7'd41: k = 64'ha81a664bbc423001;
      7'd42: k = 64'hc24b8b70d0f89791; 7'd43: k = 64'hc76c51a30654be30;
      7'd44: k = 64'hd192e819d6ef5218; 7'd45: k = 64'hd69906245565a910;
      7'd46: k = 64'hf40e35855771202a; 7'd47: k = 64'h106aa07032bbd1b8;
      7'd48: k = 64'h19a4c116b8d2d0c8; 7'd49: k = 64'h1e376c085141ab53;
      7'd50: k = 64'h2748774cdf8eeb99; 7'd51: k = 64'h34b0bcb5e19b48a8;
      7'd52: k = 64'h391c0cb3c5c95a63; 7'd53: k = 64'h4ed8aa4ae3418acb;
      7'd54: k = 64'h5b9cca4f7763e373; 7'd55: k = 64'h682e6ff3d6b2b8a3;
      7'd56: k = 64'h748f82ee5defb2fc; 7'd57: k = 64'h78a5636f43172f60;
      7'd58: k = 64'h84c87814a1f0ab72; 7'd59: k = 64'h8cc702081a6439ec;
      7'd60: k = 64'h90befffa23631e28; 7'd61: k = 64'ha4506cebde82bde9;
      7'd62: k = 64'hbef9a3f7b2c67915; 7'd63: k = 64'hc67178f2e372532b;
      7'd64: k = 64'hca273eceea26619c; 7'd65: k = 64'hd186b8c721c0c207;
      7'd66: k = 64'heada7dd6cde0eb1e; 7'd67: k = 64'hf57d4f7fee6ed178;
      7'd68: k = 64'h06f067aa72176fba; 7'd69: k = 64'h0a637dc5a2c898a6;
      7'd70: k = 64'h113f9804bef90dae; 7'd71: k = 64'h1b710b35131c471b;
      7'd72: k = 64'h28db77f523047d84; 7'd73: k = 64'h32caab7b40c72493;
      7'd74: k = 64'h3c9ebe0a15c9bebc; 7'd75: k = 64'h431d67c49c100d4c;
      7'd76: k = 64'h4cc5d4becb3e42b6; 7'd77: k = 64'h597f299cfc657e2a;
      7'd78: k = 64'h5fcb6fab3ad6faec; 7'd79: k = 64'h6c44198c4a475817;
      default: k = 64'd0;
    endcase
    return k;
  endfunction

  // Indices past the last round read as zero for either width.
  assign w_kfull = (r_t < 7'(ROUNDS)) ? k_lookup(r_t) : 64'd0;

  generate
    if (WORD_W == 64) begin : g_k64
      assign w_k = w_kfull;
    end else begin : g_k32
      logic w_unused_klo;
      assign w_k          = w_kfull[63:32];
      assign w_unused_klo = ^w_kfull[31:0];
    end
  endgenerate

  // Round function
  assign w_beat  = (r_state == ST_ROUND) && bus.msg_valid_in;
  assign w_sig1  = rotr(r_e, c_s1_r0) ^ rotr(r_e, c_s1_r1) ^ rotr(r_e, c_s1_r2);
  assign w_sig0  = rotr(r_a, c_s0_r0) ^ rotr(r_a, c_s0_r1) ^ rotr(r_a, c_s0_r2);
  assign w_ch    = (r_e & r_f) ^ (~r_e & r_g);
  assign w_maj   = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
  assign w_t1    = r_h + w_sig1 + w_ch + w_k + bus.msg_in;
  assign w_t2    = w_sig0 + w_maj;

  assign w_final = {r_a + r_hsave[8*WORD_W-1 -: WORD_W],
                    r_b + r_hsave[7*WORD_W-1 -: WORD_W],
                    r_c + r_hsave[6*WORD_W-1 -: WORD_W],
                    r_d + r_hsave[5*WORD_W-1 -: WORD_W],
                    r_e + r_hsave[4*WORD_W-1 -: WORD_W],
                    r_f + r_hsave[3*WORD_W-1 -: WORD_W],
                    r_g + r_hsave[2*WORD_W-1 -: WORD_W],
                    r_h + r_hsave[WORD_W-1:0]};

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and status outputs
  always_comb begin
    w_state_nxt       = r_state;
    bus.msg_ready_out = 1'b0;
    bus.valid_out     = 1'b0;
    bus.busy_out      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        bus.busy_out = 1'b0;
        if (bus.start_in) w_state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        bus.msg_ready_out = 1'b1;
        if (w_beat && (r_t == 7'(ROUNDS - 1))) w_state_nxt = ST_FINAL;
      end
      ST_FINAL: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.valid_out = 1'b1;
        if (!OUT_HOLD || bus.out_ready_in) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Working variables, saved chaining value, round counter and digest
  always_ff @(posedge CLK) begin
    if (RST) begin
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
      r_hsave  <= '0;
      r_digest <= '0;
      r_t      <= 7'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_in) begin
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= bus.state_in;
            r_hsave <= bus.state_in;
            r_t     <= 7'd0;
          end
        end
        ST_ROUND: begin
          if (w_beat) begin
            r_h <= r_g;
            r_g <= r_f;
            r_f <= r_e;
            r_e <= r_d + w_t1;
            r_d <= r_c;
            r_c <= r_b;
            r_b <= r_a;
            r_a <= w_t1 + w_t2;
            r_t <= r_t + 7'd1;
          end
        end
        ST_FINAL: begin
          r_digest <= w_final;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.state_out = r_digest;
  // t is left at ROUNDS after a block, so IDLE masks it to zero.
  assign bus.round_out = (r_state == ST_IDLE) ? 7'd0 : r_t;

endmodule
`default_nettype wire

// File: tb/tb_sha2_compress_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha2_compress_core
// Description : Self-checking bench for sha2_compress_core. SHA-256 and
//               SHA-512 "abc" blocks, stalls, output hold, start pulses in
//               busy states, and reset mid-block. Expected digests are queued
//               at start and compared when valid_out rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha2_compress_core;

  localparam logic [255:0] c_iv256  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] c_dig256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] c_iv512  = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
                                       64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                       64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                                       64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [511:0] c_dig512 = {64'hddaf35a193617aba, 64'hcc417349ae204131,
                                       64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
                                       64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                                       64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

  logic CLK = 1'b0;
  logic RST;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  sha2_compress_core_if #(.WORD_W(32)) bus32 ();
  sha2_compress_core_if #(.WORD_W(64)) bus64 ();

  sha2_compress_core #(.WORD_W(32), .OUT_HOLD(1'b1)) dut32 (.CLK(CLK), .RST(RST), .bus(bus32));
  sha2_compress_core #(.WORD_W(64), .OUT_HOLD(1'b1)) dut64 (.CLK(CLK), .RST(RST), .bus(bus64));

  logic [31:0]  w32 [0:63];
  logic [63:0]  w64 [0:79];
  logic [255:0] exp256_q [$];
  logic [511:0] exp512_q [$];
  logic         prev_v32 = 1'b0;
  logic         prev_v64 = 1'b0;

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: compare the oldest expected digest on each valid_out rise.
  always @(negedge CLK) begin
    if (bus32.valid_out === 1'b1 && prev_v32 !== 1'b1) begin
      chk("sb32_pending", 512'(exp256_q.size() != 0), 512'd1);
      if (exp256_q.size() != 0) chk("digest256", {256'd0, bus32.state_out}, {256'd0, exp256_q.pop_front()});
    end
    if (bus64.valid_out === 1'b1 && prev_v64 !== 1'b1) begin
      chk("sb64_pending", 512'(exp512_q.size() != 0), 512'd1);
      if (exp512_q.size() != 0) chk("digest512", bus64.state_out, exp512_q.pop_front());
    end
    prev_v32 <= bus32.valid_out;
    prev_v64 <= bus64.valid_out;
  end

  // One SHA-256 "abc" block on dut32. stall_pct: chance of msg_valid_in low;
  // poke: pulse start_in while busy; hold: cycles out_ready_in stays low.
  task automatic run256(input int stall_pct, input bit poke, input int hold);
    int           cyc, k, stalls;
    bit           beat, stall;
    logic [6:0]   rnd_before;
    logic [255:0] held;
    bus32.state_in     = c_iv256;
    bus32.out_ready_in = 1'b0;
    bus32.start_in     = 1'b1;
    exp256_q.push_back(c_dig256);
    step();
    bus32.start_in = 1'b0;
    cyc = 1; k = 0; stalls = 0;
    while (bus32.valid_out !== 1'b1 && cyc < 400) begin
      bus32.msg_valid_in = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
      bus32.msg_in       = (k < 64) ? w32[k] : 32'h0;
      if (poke) bus32.start_in = ($urandom_range(0, 2) == 0);
      beat       = bus32.msg_valid_in && bus32.msg_ready_out;
      stall      = !bus32.msg_valid_in && bus32.msg_ready_out;
      rnd_before = bus32.round_out;
      step();
      cyc++;
      if (beat) begin
        k++;
        chk("round_count", 512'(bus32.round_out), 512'(k));
      end
      if (stall) begin
        stalls++;
        chk("stall_round_frozen", 512'(bus32.round_out), 512'(rnd_before));
      end
    end
    bus32.start_in = poke;
    chk("valid_seen", 512'(bus32.valid_out), 512'd1);
    chk("latency256", 512'(cyc), 512'(66 + stalls));
    held = bus32.state_out;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 512'(bus32.valid_out), 512'd1);
      chk("hold_state", {256'd0, bus32.state_out}, {256'd0, held});
    end
    bus32.out_ready_in = 1'b1;
    step();
    bus32.out_ready_in = 1'b0;
    bus32.start_in     = 1'b0;
    bus32.msg_valid_in = 1'b0;
    chk("idle_after_accept", 512'(bus32.busy_out), 512'd0);
    chk("round_idle_zero", 512'(bus32.round_out), 512'd0);
    chk("state_kept_idle", {256'd0, bus32.state_out}, {256'd0, held});
  endtask

  int cyc64, k64;
  bit beat64;
  int kab;

  initial begin
    RST = 1'b1;
    bus32.start_in = 1'b0; bus32.state_in = '0; bus32.msg_valid_in = 1'b0;
    bus32.msg_in = '0; bus32.out_ready_in = 1'b0;
    bus64.start_in = 1'b0; bus64.state_in = '0; bus64.msg_valid_in = 1'b0;
    bus64.msg_in = '0; bus64.out_ready_in = 1'b0;

    // Message schedules for the padded "abc" block
    for (int t = 0; t < 64; t++) w32[t] = 32'h0;
    w32[0] = 32'h61626380; w32[15] = 32'h18;
    for (int t = 16; t < 64; t++)
      w32[t] = (r32(w32[t-2], 17) ^ r32(w32[t-2], 19) ^ (w32[t-2] >> 10)) + w32[t-7] +
               (r32(w32[t-15], 7) ^ r32(w32[t-15], 18) ^ (w32[t-15] >> 3)) + w32[t-16];
    for (int t = 0; t < 80; t++) w64[t] = 64'h0;
    w64[0] = 64'h6162638000000000; w64[15] = 64'h18;
    for (int t = 16; t < 80; t++)
      w64[t] = (r64(w64[t-2], 19) ^ r64(w64[t-2], 61) ^ (w64[t-2] >> 6)) + w64[t-7] +
               (r64(w64[t-15], 1) ^ r64(w64[t-15], 8) ^ (w64[t-15] >> 7)) + w64[t-16];

    // Reset state
    repeat (3) step();
    chk("rst_valid", 512'(bus32.valid_out), 512'd0);
    chk("rst_ready", 512'(bus32.msg_ready_out), 512'd0);
    chk("rst_busy", 512'(bus32.busy_out), 512'd0);
    chk("rst_round", 512'(bus32.round_out), 512'd0);
    chk("rst_state32", {256'd0, bus32.state_out}, 512'd0);
    chk("rst_state64", bus64.state_out, 512'd0);
    RST = 1'b0;
    step();
    chk("post_rst_busy", 512'(bus32.busy_out), 512'd0);
    chk("post_rst_ready", 512'(bus32.msg_ready_out), 512'd0);

    // Plain block with a 10-cycle output hold
    run256(0, 1'b0, 10);
    // Random stalls, then back-to-back with start pulses while busy
    run256(50, 1'b0, 0);
    run256(0, 1'b1, 3);

    // Reset at t=30 with start_in high in the same cycle
    bus32.state_in = c_iv256;
    bus32.start_in = 1'b1;
    step();
    bus32.start_in = 1'b0;
    kab = 0;
    while (kab < 30) begin
      bus32.msg_valid_in = 1'b1;
      bus32.msg_in       = w32[kab];
      step();
      kab++;
    end
    bus32.msg_valid_in = 1'b0;
    chk("abort_round", 512'(bus32.round_out), 512'd30);
    RST = 1'b1;
    bus32.start_in = 1'b1;
    step();
    chk("abort_valid", 512'(bus32.valid_out), 512'd0);
    chk("abort_ready", 512'(bus32.msg_ready_out), 512'd0);
    chk("abort_busy", 512'(bus32.busy_out), 512'd0);
    chk("abort_state_cleared", {256'd0, bus32.state_out}, 512'd0);
    RST = 1'b0;
    bus32.start_in = 1'b0;
    step();
    chk("abort_post_busy", 512'(bus32.busy_out), 512'd0);
    repeat (80) step();
    chk("abort_stays_idle", 512'(bus32.busy_out), 512'd0);
    run256(0, 1'b0, 0);

    // SHA-512 block
    bus64.state_in     = c_iv512;
    bus64.out_ready_in = 1'b1;
    bus64.start_in     = 1'b1;
    exp512_q.push_back(c_dig512);
    step();
    bus64.start_in = 1'b0;
    cyc64 = 1; k64 = 0;
    while (bus64.valid_out !== 1'b1 && cyc64 < 400) begin
      bus64.msg_valid_in = 1'b1;
      bus64.msg_in       = (k64 < 80) ? w64[k64] : 64'h0;
      beat64 = bus64.msg_ready_out;
      step();
      cyc64++;
      if (beat64) k64++;
    end
    chk("latency512", 512'(cyc64), 512'd82);
    bus64.msg_valid_in = 1'b0;
    step();
    chk("idle512", 512'(bus64.busy_out), 512'd0);

    repeat (2) step();
    chk("sb32_drained", 512'(exp256_q.size()), 512'd0);
    chk("sb64_drained", 512'(exp512_q.size()), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha2_compress_core.md
SHA2_COMPRESS_CORE -- requirements
Module: sha2_compress_core

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set the word width; legal values are 32 (SHA-256) and 64 (SHA-512).
REQ-002 Derived localparam ROUNDS SHALL be 64 when WORD_W=32 and 80 when WORD_W=64.
REQ-003 Parameter OUT_HOLD, default 1: 1 holds the digest until accepted; 0 makes valid_out a single-cycle pulse with no backpressure.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 start_in  input  1  request to begin compressing one block.
REQ-007 state_in  input  8*WORD_W  chaining value H0..H7, H0 in the MSBs.
REQ-008 msg_valid_in  input  1  msg_in carries schedule word W_t.
REQ-009 msg_in  input  WORD_W  schedule word W_t, supplied externally in order t=0..ROUNDS-1.
REQ-010 msg_ready_out  output  1  core accepts W_t this cycle.
REQ-011 state_out  output  8*WORD_W  updated chaining value, same packing as state_in.
REQ-012 valid_out  output  1  state_out is valid.
REQ-013 out_ready_in  input  1  consumer accepts state_out; ignored when OUT_HOLD=0.
REQ-014 busy_out  output  1  high in every state except IDLE.
REQ-015 round_out  output  7  current round index t.

Function
REQ-016 FSM states SHALL be IDLE, ROUND, FINAL and DONE.
REQ-017 IDLE: start_in=1 SHALL latch state_in into a working copy (a..h) and a saved copy (H0..H7), clear t to 0, and go to ROUND.
REQ-018 msg_ready_out SHALL be 1 only in ROUND.
REQ-019 ROUND: a round SHALL execute only on a beat, i.e. a cycle with msg_valid_in=1 and msg_ready_out=1.
REQ-020 ROUND with msg_valid_in=0 SHALL stall: a..h and t hold their values.
REQ-021 A beat SHALL compute T1=h+Sigma1(e)+Ch(e,f,g)+K[t]+W_t and T2=Sigma0(a)+Maj(a,b,c).
REQ-022 A beat SHALL update h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
REQ-023 All additions SHALL be modulo 2^WORD_W.
REQ-024 A beat SHALL increment t.
REQ-025 The beat at t=ROUNDS-1 SHALL transition to FINAL.
REQ-026 WORD_W=32 rotations SHALL be: Sigma0 rotr 2,13,22; Sigma1 rotr 6,11,25.
REQ-027 WORD_W=64 rotations SHALL be: Sigma0 rotr 28,34,39; Sigma1 rotr 14,18,41.
REQ-028 K SHALL be the FIPS 180-4 constant table for the selected width, indexed by t; index >= ROUNDS SHALL yield 0.
REQ-029 FINAL: state_out register SHALL be loaded with {a+H0, ..., h+H7}, then the FSM SHALL go to DONE in one cycle.
REQ-030 DONE: valid_out SHALL be 1.
REQ-031 DONE with OUT_HOLD=1: the FSM SHALL stay in DONE with state_out stable until out_ready_in=1, then return to IDLE.
REQ-032 DONE with OUT_HOLD=0: the FSM SHALL return to IDLE after exactly one cycle.
REQ-033 state_out SHALL keep its last value in IDLE and SHALL change only in FINAL.
REQ-034 start_in SHALL be ignored in every state except IDLE.
REQ-035 start_in in the IDLE cycle that follows DONE SHALL be accepted, giving back-to-back blocks with one idle cycle between them.
REQ-036 Latency with msg_valid_in held high SHALL be: start accepted at cycle 0, beats at cycles 1..ROUNDS, FINAL at ROUNDS+1, valid_out first high at ROUNDS+2.
REQ-037 round_out SHALL equal t zero-extended to 7 bits, and SHALL read 0 in IDLE.

Reset
REQ-038 RST=1 at a rising edge SHALL force IDLE, a..h=0, H0..H7=0, t=0, state_out=0.
REQ-039 While RST=1 and in the cycle after reset, valid_out, msg_ready_out and busy_out SHALL be 0.
REQ-040 Reset SHALL override every other input, including RST asserted mid-ROUND or in DONE; the block in progress SHALL be abandoned with no valid_out.
REQ-041 start_in sampled in the same cycle as RST=1 SHALL be ignored.

Verification
REQ-042 WORD_W=32, SHA-256 IV, "abc" padded block (W0=0x61626380, W15=0x18, W16..63 from bench model), msg_valid_in always 1 -> state_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with valid_out rising at cycle 66.
REQ-043 WORD_W=64, SHA-512 IV, "abc" block (W0=0x6162638000000000, W15=0x18) -> state_out begins ddaf35a193617aba and ends a54ca49f, with valid_out rising at cycle 82.
REQ-044 Repeat REQ-042 with msg_valid_in randomly low 50% of cycles -> identical digest; a..h and round_out frozen on every stall cycle.
REQ-045 OUT_HOLD=1, out_ready_in held 0 for 10 cycles -> valid_out and state_out stable for 10 cycles; IDLE one cycle after out_ready_in=1.
REQ-046 RST=1 at t=30, then a new start_in -> no valid_out for the aborted block; the new block yields the REQ-042 digest.
REQ-047 start_in pulsed during ROUND and DONE -> ignored; digest unchanged and round count unaffected.
